vga_bus_host: RTL and testbench
===============================

// Module: vga_bus_host
// PURPOSE
//  Host-side initiator for the VGA core's 8-bit async-style register bus (ncs/nwr/nrd/ext_address/db/wait_sig).
//  Converts single-beat valid/ready requests from a local controller into timed bus cycles.
//  Stretches the strobe while the peripheral holds wait_sig and returns read data/completion.
//  Lives on the system side; drives the VGA core's bus pins in synthesis and replaces hand-timed bench tasks.
// PARAMETERS
//  ADDR_W          4    bus address width
//  DATA_W          8    bus data width
//  SETUP_CYCLES    1    addr/data valid before ncs/strobe fall (>=1)
//  STROBE_CYCLES   5    minimum ncs+nwr/nrd low time (>=1)
//  HOLD_CYCLES     1    addr/data held after strobes rise (>=1)
//  GAP_CYCLES      10   idle bus time before next request is accepted (>=1)
//  TIMEOUT_CYCLES  256  wait_sig limit, used only with VGA_BUS_TIMEOUT_EN
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when valid&&ready
//  req_write    in   1       1=write, 0=read
//  req_addr     in   ADDR_W  register address
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       one-cycle completion pulse
//  rsp_rdata    out  DATA_W  read data (valid with rsp_valid on reads)
//  rsp_err      out  1       timeout flag, qualified by rsp_valid
//  ncs          out  1       bus chip select, active low
//  nwr          out  1       bus write strobe, active low
//  nrd          out  1       bus read strobe, active low
//  ext_address  out  ADDR_W  bus address
//  db_out       out  DATA_W  data to peripheral
//  db_oe        out  1       data driver enable (writes only)
//  db_in        in   DATA_W  data from peripheral
//  wait_sig     in   1       peripheral busy, active high, synchronous to clk
// BEHAVIOUR
//  Reset: ncs=nwr=nrd=1, ext_address=0, db_out=0, db_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE.
//  Async reset mid-cycle: all outputs to reset values at once; no rsp for aborted cycle.
//  All bus outputs registered; one phase down-counter shared by all states.
//  FSM IDLE->SETUP->STROBE->HOLD->GAP->IDLE. req_ready=1 only in IDLE (first cycle after reset release included).
//  IDLE: on valid&&ready latch write/addr/wdata; next cycle ext_address/db_out valid, db_oe=write; ncs still 1.
//  SETUP: SETUP_CYCLES cycles, then ncs=0 and nwr=0 (write) or nrd=0 (read) in the same cycle.
//  STROBE: lasts >= STROBE_CYCLES; exits on first cycle with count==0 && !wait_sig; wait_sig high earlier only extends once min reached.
//  Read data: db_in sampled on the exit cycle of STROBE into rsp_rdata; writes leave rsp_rdata unchanged.
//  HOLD: ncs/nwr/nrd=1; rsp_valid=1 on first HOLD cycle only; addr/db_out/db_oe held HOLD_CYCLES.
//  GAP: db_oe=0, strobes high, address held; GAP_CYCLES then IDLE. Requests during non-IDLE wait (req_ready=0).
//  Never assert nwr and nrd together; ncs low iff exactly one strobe low.
//  Counter width $clog2(max(all cycle params, TIMEOUT_CYCLES)+1); no wrap - reloads on every state entry.
// CONFIGURATION
//  VGA_BUS_TIMEOUT_EN defined: second counter runs while STROBE is extended by wait_sig; after TIMEOUT_CYCLES
//   extension cycles force exit to HOLD, rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF on reads.
//  Undefined: wait_sig extends indefinitely; rsp_err tied 0; port list unchanged.
// STRUCTURE
//  vga_bus_pkg: state enum {IDLE,SETUP,STROBE,HOLD,GAP}; register map constants REG_STATUS=4'h0, REG_CTRL=4'h2, REG_DATA=4'h3.
//  No sub-module: single FSM + phase counter (+ timeout counter under macro) in one file.
// TESTING
//  (clk period 4 ns, default params, wait_sig=0 unless stated)
//  1 Write addr 2 data 8'h01 -> ncs/nwr low 5 clk starting 1 clk after accept, ext_address=2, db_out=01, db_oe high SETUP..HOLD, rsp_valid 1 pulse, nrd stays 1.
//  2 Read addr 3, db_in=8'h42 -> nrd low 5 clk, rsp_rdata=42 with rsp_valid, db_oe=0 throughout.
//  3 Read addr 0, wait_sig high 8 clk from strobe start -> strobe low exactly 9 clk, data sampled cycle wait drops.
//  4 Back-to-back requests (req_valid held) -> req_ready only in IDLE, >=10 clk with ncs=1 between cycles, order preserved.
//  5 rst_n low during STROBE of a write -> ncs/nwr/db_oe immediately reset values, no rsp_valid, next request runs normally.
//  6 VGA_BUS_TIMEOUT_EN, wait_sig stuck high -> exit after 5+256 strobe clk, rsp_err=1, rsp_rdata=FF; without macro strobe stays low.

Source files
------------

// File: rtl/vga_bus_pkg.sv
// Shared types and constants for the VGA core register-bus host.
// Holds the bus FSM state encoding and the peripheral register map.
// Optional wait_sig timeout in vga_bus_host is enabled with macro VGA_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
package vga_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } bus_state_t;

  // VGA core register map
  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_CTRL   = 4'h2;
  localparam logic [3:0] REG_DATA   = 4'h3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_bus_host.sv
// Host initiator: turns single-beat valid/ready requests into timed ncs/nwr/nrd bus cycles.
// Latency: strobe falls 1+SETUP_CYCLES-1 clk after accept, rsp_valid pulses on the first HOLD cycle.
// Backpressure: req_ready only in IDLE; wait_sig stretches the strobe (bounded with VGA_BUS_TIMEOUT_EN).
`timescale 1ns/1ps
module vga_bus_host
  import vga_bus_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 5,
  parameter int HOLD_CYCLES    = 1,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ncs,
  output logic              nwr,
  output logic              nrd,
  output logic [ADDR_W-1:0] ext_address,
  output logic [DATA_W-1:0] db_out,
  output logic              db_oe,
  input  logic [DATA_W-1:0] db_in,
  input  logic              wait_sig
);

  // Counter wide enough for the longest phase or the timeout limit
  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYCLES, STROBE_CYCLES),
                                         max_of(HOLD_CYCLES, GAP_CYCLES)), TIMEOUT_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  bus_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_q, wr_nxt;
  logic              ncs_nxt, nwr_nxt, nrd_nxt, oe_nxt, rvld_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt, rdata_nxt;
`ifdef VGA_BUS_TIMEOUT_EN
  logic [CNT_W-1:0]  tcnt, tcnt_nxt;
  logic              err_q, err_nxt;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Ready is combinational from state so the first cycle out of reset can accept
  assign req_ready = (state == IDLE) && rst_n;

  // State, phase counter and all registered bus/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      ncs         <= 1'b1;
      nwr         <= 1'b1;
      nrd         <= 1'b1;
      ext_address <= '0;
      db_out      <= '0;
      db_oe       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef VGA_BUS_TIMEOUT_EN
      tcnt        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wr_q        <= wr_nxt;
      ncs         <= ncs_nxt;
      nwr         <= nwr_nxt;
      nrd         <= nrd_nxt;
      ext_address <= addr_nxt;
      db_out      <= dout_nxt;
      db_oe       <= oe_nxt;
      rsp_valid   <= rvld_nxt;
      rsp_rdata   <= rdata_nxt;
`ifdef VGA_BUS_TIMEOUT_EN
      tcnt        <= tcnt_nxt;
      err_q       <= err_nxt;
`endif
    end
  end

  // Next-state and next-output decode; counter reloads on every state entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr_q;
    ncs_nxt   = ncs;
    nwr_nxt   = nwr;
    nrd_nxt   = nrd;
    addr_nxt  = ext_address;
    dout_nxt  = db_out;
    oe_nxt    = db_oe;
    rvld_nxt  = 1'b0;
    rdata_nxt = rsp_rdata;
`ifdef VGA_BUS_TIMEOUT_EN
    tcnt_nxt  = tcnt;
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SETUP;
          cnt_nxt   = LD_SETUP;
          wr_nxt    = req_write;
          addr_nxt  = req_addr;
          dout_nxt  = req_wdata;
          oe_nxt    = req_write;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = LD_STROBE;
          ncs_nxt   = 1'b0;
          nwr_nxt   = !wr_q;
          nrd_nxt   = wr_q;
`ifdef VGA_BUS_TIMEOUT_EN
          tcnt_nxt  = '0;
`endif
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (!wait_sig) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
          ncs_nxt   = 1'b1;
          nwr_nxt   = 1'b1;
          nrd_nxt   = 1'b1;
          rvld_nxt  = 1'b1;
          if (!wr_q) rdata_nxt = db_in;
`ifdef VGA_BUS_TIMEOUT_EN
          err_nxt   = 1'b0;
        end else if (tcnt == TO_LIM) begin
          // Peripheral never released wait_sig: abandon the cycle with an error
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
          ncs_nxt   = 1'b1;
          nwr_nxt   = 1'b1;
          nrd_nxt   = 1'b1;
          rvld_nxt  = 1'b1;
          err_nxt   = 1'b1;
          if (!wr_q) rdata_nxt = '1;
        end else begin
          tcnt_nxt = tcnt + CNT_ONE;
`endif
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = LD_GAP;
          oe_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_bus_host.sv
// Directed self-checking bench for vga_bus_host with default parameters.
// Each transaction is traced cycle by cycle and summarised for checking.
// Timeout expectations switch on VGA_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_vga_bus_host;
  import vga_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr, ext_address;
  logic [7:0] req_wdata, rsp_rdata, db_out, db_in;
  logic       rsp_valid, rsp_err, ncs, nwr, nrd, db_oe, wait_sig;

  int checks = 0;
  int errors = 0;

  int         lat, slen, busy, oe_cyc, rv_cnt;
  logic [7:0] rd;
  logic       er, bad;
  int         lat_a, slen_a, busy_a, cnt_rv, cnt_lo;

  vga_bus_host dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .ext_address(ext_address),
    .db_out(db_out), .db_oe(db_oe), .db_in(db_in), .wait_sig(wait_sig)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and trace it until the host is ready again.
  // c=0 is the first sample after the accepting edge.
  task automatic do_txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input int wlen, input logic ramp,
                        input logic nxt_vld, input logic [3:0] na);
    int c;
    lat = -1; slen = 0; busy = 0; oe_cyc = 0; rv_cnt = 0; rd = 8'hxx; er = 1'b0; bad = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    db_in = d;
    check("ready_before_accept", req_ready, 1);
    tick();
    req_valid = nxt_vld; req_write = 1'b0; req_addr = na; req_wdata = 8'h00;
    c = 0;
    while (!req_ready && c < 600) begin
      if (!nwr && !nrd) bad = 1'b1;
      if ((ncs == 1'b0) != (nwr ^ nrd)) bad = 1'b1;
      if (!ncs) begin
        if (lat < 0) lat = c;
        if (wr ? nwr : nrd) bad = 1'b1;
        if (ext_address != a) bad = 1'b1;
        if (wr && db_out != d) bad = 1'b1;
        if (!wr && ramp) db_in = d + 8'(slen);
        wait_sig = (slen < wlen);
        slen++;
      end else begin
        wait_sig = 1'b0;
      end
      if (db_oe) oe_cyc++;
      if (rsp_valid) begin
        rv_cnt++;
        rd = rsp_rdata;
        er = rsp_err;
      end
      busy++;
      tick();
      c++;
    end
    wait_sig = 1'b0;
    if (!req_ready) bad = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; db_in = '0; wait_sig = 1'b0;
    #5;
    // Reset values
    check("rst_ncs", ncs, 1);
    check("rst_nwr", nwr, 1);
    check("rst_nrd", nrd, 1);
    check("rst_addr", ext_address, 0);
    check("rst_db_out", db_out, 0);
    check("rst_db_oe", db_oe, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    #1 rst_n = 1'b1;
    #1 check("ready_after_release", req_ready, 1);
    tick();

    // 1: write REG_CTRL = 01
    do_txn(1'b1, REG_CTRL, 8'h01, 0, 1'b0, 1'b0, 4'h0);
    check("t1_lat", lat, 1);
    check("t1_strobe_len", slen, 5);
    check("t1_db_oe_cycles", oe_cyc, 7);
    check("t1_rsp_pulses", rv_cnt, 1);
    check("t1_rdata_unchanged", rd, 8'h00);
    check("t1_err", er, 0);
    check("t1_busy", busy, 17);
    check("t1_protocol", bad, 0);

    // 2: read REG_DATA, peripheral returns 42
    do_txn(1'b0, REG_DATA, 8'h42, 0, 1'b0, 1'b0, 4'h0);
    check("t2_strobe_len", slen, 5);
    check("t2_rdata", rd, 8'h42);
    check("t2_db_oe_cycles", oe_cyc, 0);
    check("t2_rsp_pulses", rv_cnt, 1);
    check("t2_protocol", bad, 0);

    // 3: read REG_STATUS with wait_sig high for the first 8 strobe clocks; db_in ramps 10,11,..
    do_txn(1'b0, REG_STATUS, 8'h10, 8, 1'b1, 1'b0, 4'h0);
    check("t3_strobe_len", slen, 9);
    check("t3_rdata_at_wait_drop", rd, 8'h18);
    check("t3_busy", busy, 21);
    check("t3_protocol", bad, 0);

    // 4: back-to-back, valid held: write CTRL=5A then read DATA
    do_txn(1'b1, REG_CTRL, 8'h5A, 0, 1'b0, 1'b1, REG_DATA);
    lat_a = lat; slen_a = slen; busy_a = busy;
    check("t4a_busy_not_ready", busy_a, 17);
    check("t4a_protocol", bad, 0);
    do_txn(1'b0, REG_DATA, 8'h77, 0, 1'b0, 1'b0, 4'h0);
    check("t4_gap_ncs_high", (busy_a - lat_a - slen_a) + 1 + lat, 13);
    check("t4b_rdata", rd, 8'h77);
    check("t4b_protocol", bad, 0);

    // 5: async reset during the strobe of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = REG_CTRL; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    tick();
    check("t5_strobe_active", ncs, 0);
    tick();
    #1 rst_n = 1'b0;
    #0.5;
    check("t5_ncs", ncs, 1);
    check("t5_nwr", nwr, 1);
    check("t5_db_oe", db_oe, 0);
    check("t5_addr", ext_address, 0);
    check("t5_ready", req_ready, 0);
    tick();
    tick();
    #1 rst_n = 1'b1;
    #0.5 check("t5_ready_after_release", req_ready, 1);
    cnt_rv = 0; cnt_lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) cnt_rv++;
      if (!ncs) cnt_lo++;
    end
    check("t5_no_rsp", cnt_rv, 0);
    check("t5_no_resume", cnt_lo, 0);
    do_txn(1'b1, REG_DATA, 8'hC3, 0, 1'b0, 1'b0, 4'h0);
    check("t5_next_strobe_len", slen, 5);
    check("t5_next_rsp", rv_cnt, 1);
    check("t5_next_protocol", bad, 0);

    // 6: wait_sig held high for 300 strobe clocks
    do_txn(1'b0, REG_STATUS, 8'h3C, 300, 1'b0, 1'b0, 4'h0);
`ifdef VGA_BUS_TIMEOUT_EN
    check("t6_strobe_len", slen, 261);
    check("t6_err", er, 1);
    check("t6_rdata", rd, 8'hFF);
`else
    check("t6_strobe_len", slen, 301);
    check("t6_err", er, 0);
    check("t6_rdata", rd, 8'h3C);
`endif
    check("t6_rsp_pulses", rv_cnt, 1);
    check("t6_protocol", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
